// File: rtl/myproject_sdiv_26s_12s_16_seq.sv
// Sequential signed restoring divider: din0 / din1 -> saturated quot, C-style rem.
// Ports: clk, reset, ce; in_valid/in_ready + din0/din1; out_valid/out_ready + quot/rem/ovf/div0.
module myproject_sdiv_26s_12s_16_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 26,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  div0
);

  localparam int LATENCY = din0_WIDTH + 2;
  localparam int CW      = $clog2(LATENCY);
  localparam int RW      = din1_WIDTH + 1;

  localparam logic [din0_WIDTH-1:0] QP =
    din0_WIDTH'((1 << (dout_WIDTH-1)) - 1);
  localparam logic [din0_WIDTH-1:0] QN =
    din0_WIDTH'(1 << (dout_WIDTH-1));
  localparam logic [dout_WIDTH-1:0] QMAX =
    {1'b0, {(dout_WIDTH-1){1'b1}}};
  localparam logic [dout_WIDTH-1:0] QMIN =
    {1'b1, {(dout_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_t;

  state_t state, nxt;

  logic [CW-1:0]         cnt;
  logic                  sa, sb, zl;
  // dividend bits shift out the top while quotient bits shift in below
  logic [din0_WIDTH-1:0] dq;
  logic [din1_WIDTH-1:0] dmag;
  logic [din1_WIDTH-1:0] rp;
  logic [RW-1:0]         sh, diff;
  logic [din0_WIDTH-1:0] a0;
  logic [din1_WIDTH-1:0] a1;
  logic [dout_WIDTH-1:0] fq;
  logic [din1_WIDTH-1:0] fr;
  logic                  fo;
  logic                  acc, last;

  assign acc  = in_valid && in_ready;
  assign last = (cnt == CW'(din0_WIDTH-1));

  // -2^(W-1) negates to itself, which read unsigned is the right magnitude
  assign a0 = din0[din0_WIDTH-1] ? -din0 : din0;
  assign a1 = din1[din1_WIDTH-1] ? -din1 : din1;

  assign sh   = {rp, dq[din0_WIDTH-1]};
  assign diff = sh - {1'b0, dmag};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else if (ce) state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (acc) nxt = CALC;
      CALC: if (last) nxt = FIX;
      FIX:  nxt = DONE;
      DONE: if (out_valid && out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // sign fix-up and saturation of the finished magnitudes
  always_comb begin
    fq = '0;
    fo = 1'b0;
    fr = sa ? -rp : rp;
    if (zl) begin
      fq = sa ? QMIN : QMAX;
      fr = '0;
      fo = 1'b1;
    end else if (sa ^ sb) begin
      if (dq > QN) begin
        fq = QMIN;
        fo = 1'b1;
      end else begin
        fq = -dq[dout_WIDTH-1:0];
      end
    end else begin
      if (dq > QP) begin
        fq = QMAX;
        fo = 1'b1;
      end else begin
        fq = dq[dout_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      ovf       <= 1'b0;
      div0      <= 1'b0;
      cnt       <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      zl        <= 1'b0;
      dq        <= '0;
      dmag      <= '0;
      rp        <= '0;
    end else if (ce) begin
      in_ready  <= (nxt == IDLE);
      // one settle cycle in DONE before the result is offered
      out_valid <= (state == DONE) && (nxt == DONE);
      case (state)
        IDLE: begin
          if (acc) begin
            sa   <= din0[din0_WIDTH-1];
            sb   <= din1[din1_WIDTH-1];
            zl   <= (din1 == '0);
            dq   <= a0;
            dmag <= a1;
            rp   <= '0;
            cnt  <= '0;
          end
        end
        CALC: begin
          if (!diff[RW-1]) begin
            rp <= diff[din1_WIDTH-1:0];
            dq <= {dq[din0_WIDTH-2:0], 1'b1};
          end else begin
            rp <= sh[din1_WIDTH-1:0];
            dq <= {dq[din0_WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          quot <= fq;
          rem  <= fr;
          ovf  <= fo;
          div0 <= zl;
        end
        default: ;
      endcase
    end
  end

endmodule
